// File: rtl/bus_pkg.sv
// Shared definitions for the RV32I data-side bus responder: region decode
// outcome, timer register offsets and CTRL/STATUS bit positions.
package bus_pkg;

  typedef enum logic [1:0] {
    REGION_RAM  = 2'd0,
    REGION_MMIO = 2'd1,
    REGION_NONE = 2'd2
  } region_e;

  // Word offsets (addr[3:2]) inside the 16-byte timer block
  localparam logic [1:0] MTIME_OFS    = 2'd0;
  localparam logic [1:0] MTIMECMP_OFS = 2'd1;
  localparam logic [1:0] STATUS_OFS   = 2'd2;
  localparam logic [1:0] CTRL_OFS     = 2'd3;

  // Bit positions
  localparam int CTRL_CNT_EN_BIT    = 0;
  localparam int CTRL_IRQ_EN_BIT    = 1;
  localparam int STATUS_PENDING_BIT = 0;

endpackage

// File: rtl/mmio_timer.sv
// Memory-mapped timer: free-running MTIME, compare register, W1C pending
// flag, control bits and a registered level interrupt.
module mmio_timer
  import bus_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_en,
  input  logic [1:0]  i_ofs,
  input  logic [31:0] i_wrdata,
  output logic [31:0] o_rddata,
  output logic        o_irq
);

  logic [31:0] r_mtime;
  logic [31:0] r_mtimecmp;
  logic [1:0]  r_ctrl;
  logic        r_pending;
  logic        r_irq;

  logic [31:0] w_mtime_next;
  logic        w_count_en;
  logic        w_wr_mtime;
  logic        w_wr_cmp;
  logic        w_wr_status;
  logic        w_wr_ctrl;
  logic        w_set_pending;
  logic        w_clr_pending;

  // Write decode, increment value and pending set/clear conditions
  always_comb begin
    w_count_en    = r_ctrl[CTRL_CNT_EN_BIT];
    w_mtime_next  = r_mtime + 32'd1;
    w_wr_mtime    = i_wr_en && (i_ofs == MTIME_OFS);
    w_wr_cmp      = i_wr_en && (i_ofs == MTIMECMP_OFS);
    w_wr_status   = i_wr_en && (i_ofs == STATUS_OFS);
    w_wr_ctrl     = i_wr_en && (i_ofs == CTRL_OFS);
    // A software MTIME write suppresses both the increment and the compare
    w_set_pending = w_count_en && !w_wr_mtime && (w_mtime_next == r_mtimecmp);
    w_clr_pending = w_wr_status && i_wrdata[STATUS_PENDING_BIT];
  end

  // Timer register file; a coincident set beats a W1C clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mtime    <= 32'd0;
      r_mtimecmp <= 32'hFFFF_FFFF;
      r_ctrl     <= 2'b00;
      r_pending  <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr_mtime) begin
        r_mtime <= i_wrdata;
      end else if (w_count_en) begin
        r_mtime <= w_mtime_next;
      end
      if (w_wr_cmp) begin
        r_mtimecmp <= i_wrdata;
      end
      if (w_wr_ctrl) begin
        r_ctrl <= i_wrdata[1:0];
      end
      if (w_set_pending) begin
        r_pending <= 1'b1;
      end else if (w_clr_pending) begin
        r_pending <= 1'b0;
      end
      r_irq <= r_pending & r_ctrl[CTRL_IRQ_EN_BIT];
    end
  end

  // Read mux over pre-edge register values
  always_comb begin
    o_rddata = 32'd0;
    case (i_ofs)
      MTIME_OFS:    o_rddata = r_mtime;
      MTIMECMP_OFS: o_rddata = r_mtimecmp;
      STATUS_OFS:   o_rddata = {31'd0, r_pending};
      CTRL_OFS:     o_rddata = {30'd0, r_ctrl};
      default:      o_rddata = 32'd0;
    endcase
  end

  assign o_irq = r_irq;

endmodule

// File: rtl/rv32i_bus_responder.sv
// Data-side bus target for the RV32I core: decodes RAM / timer / unmapped,
// returns read data one cycle after the strobe and flags bad accesses.
module rv32i_bus_responder
  import bus_pkg::*;
#(
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] RAM_BASE  = 32'h1001_0000,
  parameter logic [31:0] MMIO_BASE = 32'h1002_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wrdata,
  input  logic        bus_wren,
  input  logic        bus_rden,
  output logic [31:0] bus_rddata,
  output logic        irq,
  output logic        addr_err
);

  localparam int          IDX_W     = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0]      r_mem [RAM_WORDS];
  logic [31:0]      r_rddata;
  logic             r_addr_err;

  region_e          w_region;
  logic [31:0]      w_ram_ofs;
  logic [IDX_W-1:0] w_ram_idx;
  logic             w_ram_we;
  logic             w_tmr_we;
  logic             w_rd_ok;
  logic             w_err;
  logic [31:0]      w_tmr_rddata;

  // Address decode and strobe qualification
  always_comb begin
    w_ram_ofs = bus_addr - RAM_BASE;
    w_ram_idx = w_ram_ofs[IDX_W+1:2];
    if ((bus_addr >= RAM_BASE) && (w_ram_ofs < RAM_BYTES)) begin
      w_region = REGION_RAM;
    end else if (bus_addr[31:4] == MMIO_BASE[31:4]) begin
      w_region = REGION_MMIO;
    end else begin
      w_region = REGION_NONE;
    end
    w_ram_we = bus_wren && (w_region == REGION_RAM);
    w_tmr_we = bus_wren && (w_region == REGION_MMIO);
    // A colliding read is discarded so the write alone takes effect
    w_rd_ok  = bus_rden && !bus_wren;
    w_err    = (bus_wren || bus_rden) &&
               ((w_region == REGION_NONE) || (bus_wren && bus_rden));
  end

  // Data RAM: whole-word writes, contents survive reset
  always_ff @(posedge clk) begin
    if (rst && w_ram_we) begin
      r_mem[w_ram_idx] <= bus_wrdata;
    end
  end

  // Read-data register and single-cycle error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rddata   <= 32'd0;
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= w_err;
      if (w_rd_ok) begin
        case (w_region)
          REGION_RAM:  r_rddata <= r_mem[w_ram_idx];
          REGION_MMIO: r_rddata <= w_tmr_rddata;
          default:     r_rddata <= 32'd0;
        endcase
      end
    end
  end

  mmio_timer u_timer (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_wr_en  (w_tmr_we),
    .i_ofs    (bus_addr[3:2]),
    .i_wrdata (bus_wrdata),
    .o_rddata (w_tmr_rddata),
    .o_irq    (irq)
  );

  assign bus_rddata = r_rddata;
  assign addr_err   = r_addr_err;

endmodule

// File: tb/tb_rv32i_bus_responder.sv
// Directed self-checking bench for rv32i_bus_responder.
module tb_rv32i_bus_responder;

  localparam logic [31:0] RAM_BASE  = 32'h1001_0000;
  localparam logic [31:0] MMIO_BASE = 32'h1002_0000;

  logic        clk;
  logic        rst;
  logic [31:0] bus_addr;
  logic [31:0] bus_wrdata;
  logic        bus_wren;
  logic        bus_rden;
  logic [31:0] bus_rddata;
  logic        irq;
  logic        addr_err;

  int total;
  int bad;

  rv32i_bus_responder #(
    .RAM_WORDS (1024),
    .RAM_BASE  (RAM_BASE),
    .MMIO_BASE (MMIO_BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_addr   (bus_addr),
    .bus_wrdata (bus_wrdata),
    .bus_wren   (bus_wren),
    .bus_rden   (bus_rden),
    .bus_rddata (bus_rddata),
    .irq        (irq),
    .addr_err   (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; outputs settle 1 time unit later
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_addr = a; bus_wrdata = d; bus_wren = 1'b1;
    cycle();
    bus_wren = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a);
    bus_addr = a; bus_rden = 1'b1;
    cycle();
    bus_rden = 1'b0;
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    bus_write(RAM_BASE + 32'h10, 32'h1234_5678);
    bus_read(RAM_BASE + 32'h10);
    chk32("pre_reset_rddata", bus_rddata, 32'h1234_5678);
    bus_write(MMIO_BASE + 32'h4, 32'd2);
    bus_write(MMIO_BASE + 32'hC, 32'd3);
    for (int i = 0; i < 20; i++) begin
      if (irq !== 1'b1) cycle();
    end
    chk1("pre_reset_irq", irq, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk32("reset_rddata", bus_rddata, 32'd0);
    chk1("reset_irq", irq, 1'b0);
    chk1("reset_addr_err", addr_err, 1'b0);
    cycle();
    cycle();
    rst = 1'b1;
    bus_read(MMIO_BASE + 32'h4);
    chk32("reset_mtimecmp", bus_rddata, 32'hFFFF_FFFF);
    bus_read(MMIO_BASE + 32'hC);
    chk32("reset_ctrl", bus_rddata, 32'd0);
    bus_read(MMIO_BASE + 32'h8);
    chk32("reset_status", bus_rddata, 32'd0);
    bus_read(MMIO_BASE + 32'h0);
    chk32("reset_mtime", bus_rddata, 32'd0);
    bus_read(RAM_BASE + 32'h10);
    chk32("ram_survives_reset", bus_rddata, 32'h1234_5678);
  endtask

  task automatic test_ram();
    bus_write(RAM_BASE + 32'h4, 32'hCAFE_F00D);
    bus_read(RAM_BASE + 32'h7);
    chk32("ram_read_unaligned", bus_rddata, 32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk32("ram_rddata_hold", bus_rddata, 32'hCAFE_F00D);
    end
    bus_write(RAM_BASE + 32'hFFC, 32'hA5A5_0FFC);
    bus_read(RAM_BASE + 32'hFFC);
    chk32("ram_last_word", bus_rddata, 32'hA5A5_0FFC);
  endtask

  task automatic test_timer_irq();
    bus_write(MMIO_BASE + 32'h4, 32'd10);
    bus_write(MMIO_BASE + 32'hC, 32'd3);
    bus_write(MMIO_BASE + 32'h0, 32'd0);
    repeat (9) cycle();
    chk1("tmr_irq_before_match", irq, 1'b0);
    bus_read(MMIO_BASE + 32'h8);
    chk32("tmr_status_before_set", bus_rddata, 32'd0);
    chk1("tmr_irq_at_set_edge", irq, 1'b0);
    cycle();
    chk1("tmr_irq_rises", irq, 1'b1);
    bus_read(MMIO_BASE + 32'h8);
    chk32("tmr_status_pending", bus_rddata, 32'd1);
    bus_read(MMIO_BASE + 32'h0);
    chk32("tmr_mtime_count", bus_rddata, 32'd12);
    bus_write(MMIO_BASE + 32'h8, 32'd1);
    chk1("tmr_irq_at_clear_edge", irq, 1'b1);
    cycle();
    chk1("tmr_irq_cleared", irq, 1'b0);
    bus_read(MMIO_BASE + 32'h8);
    chk32("tmr_status_cleared", bus_rddata, 32'd0);
  endtask

  task automatic test_wrap();
    bus_write(MMIO_BASE + 32'h4, 32'd0);
    bus_write(MMIO_BASE + 32'h0, 32'hFFFF_FFFE);
    chk1("wrap_irq_idle0", irq, 1'b0);
    cycle();
    chk1("wrap_irq_idle1", irq, 1'b0);
    bus_read(MMIO_BASE + 32'h0);
    chk32("wrap_mtime_max", bus_rddata, 32'hFFFF_FFFF);
    chk1("wrap_irq_at_set", irq, 1'b0);
    bus_read(MMIO_BASE + 32'h0);
    chk32("wrap_mtime_zero", bus_rddata, 32'd0);
    chk1("wrap_irq_rises", irq, 1'b1);
    bus_write(MMIO_BASE + 32'hC, 32'd0);
    bus_write(MMIO_BASE + 32'h8, 32'd1);
    cycle();
    chk1("wrap_irq_off", irq, 1'b0);
  endtask

  task automatic test_miss();
    bus_read(RAM_BASE + 32'h4);
    chk32("miss_pre_rddata", bus_rddata, 32'hCAFE_F00D);
    bus_read(32'h0000_0000);
    chk32("miss_read_zero", bus_rddata, 32'd0);
    chk1("miss_read_err", addr_err, 1'b1);
    cycle();
    chk1("miss_read_err_drop", addr_err, 1'b0);
    bus_write(RAM_BASE, 32'h1111_2222);
    chk1("ram_write_no_err", addr_err, 1'b0);
    bus_write(RAM_BASE + 32'h1000, 32'hDEAD_BEEF);
    chk1("miss_write_err", addr_err, 1'b1);
    cycle();
    chk1("miss_write_err_drop", addr_err, 1'b0);
    bus_read(RAM_BASE);
    chk32("miss_write_ram_intact", bus_rddata, 32'h1111_2222);
    bus_read(MMIO_BASE + 32'h10);
    chk1("miss_past_mmio_err", addr_err, 1'b1);
    chk32("miss_past_mmio_data", bus_rddata, 32'd0);
  endtask

  task automatic test_collision();
    bus_read(RAM_BASE + 32'h4);
    bus_addr = RAM_BASE; bus_wrdata = 32'h55AA_55AA;
    bus_wren = 1'b1; bus_rden = 1'b1;
    cycle();
    bus_wren = 1'b0; bus_rden = 1'b0;
    chk32("coll_rddata_hold", bus_rddata, 32'hCAFE_F00D);
    chk1("coll_err", addr_err, 1'b1);
    cycle();
    chk1("coll_err_drop", addr_err, 1'b0);
    bus_read(RAM_BASE);
    chk32("coll_write_done", bus_rddata, 32'h55AA_55AA);
  endtask

  task automatic test_back_to_back();
    bus_rden = 1'b1;
    bus_addr = RAM_BASE + 32'h4;
    cycle();
    chk32("b2b_read0", bus_rddata, 32'hCAFE_F00D);
    bus_addr = RAM_BASE + 32'hFFC;
    cycle();
    chk32("b2b_read1", bus_rddata, 32'hA5A5_0FFC);
    bus_addr = MMIO_BASE + 32'h4;
    cycle();
    chk32("b2b_read2", bus_rddata, 32'd0);
    chk1("b2b_no_err", addr_err, 1'b0);
    bus_rden = 1'b0;
    bus_write(RAM_BASE + 32'h8, 32'h0BAD_C0DE);
    bus_read(RAM_BASE + 32'h8);
    chk32("b2b_write_then_read", bus_rddata, 32'h0BAD_C0DE);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst        = 1'b0;
    bus_addr   = 32'd0;
    bus_wrdata = 32'd0;
    bus_wren   = 1'b0;
    bus_rden   = 1'b0;
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    test_reset();
    test_ram();
    test_timer_irq();
    test_wrap();
    test_miss();
    test_collision();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
